// File: rtl/mips_branch_pkg.sv
// Shared types and helpers for the EX-stage branch resolution logic.
// Branch opcode encodings, FSM states, and the condition/target arithmetic
// used by the resolver.
package mips_branch_pkg;

  // Branch/jump operation carried down the pipe with each EX instruction.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BLEZ = 3'd3,
    OP_BGTZ = 3'd4,
    OP_BLTZ = 3'd5,
    OP_BGEZ = 3'd6,
    OP_J    = 3'd7
  } branch_op_t;

  // Resolver FSM: IDLE evaluates branches, SQUASH kills wrong-path work.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  // Width of the squash down-counter; holds squash lengths 1..7.
  localparam int unsigned SQZ_W = 3;

  // Branch condition from the ALU zero flag and sign bit.
  // sign & zero together cannot occur for a real ALU result.
  function automatic logic branch_cond(branch_op_t op, logic zero, logic sign);
    logic take;
    case (op)
      OP_BEQ:  take = zero;
      OP_BNE:  take = ~zero;
      OP_BLEZ: take = sign | zero;
      OP_BGTZ: take = ~sign & ~zero;
      OP_BLTZ: take = sign;
      OP_BGEZ: take = ~sign;
      OP_J:    take = 1'b1;
      default: take = 1'b0;
    endcase
    return take;
  endfunction

  // PC-relative target: word offset added to PC+4, carry out discarded.
  function automatic logic [31:0] branch_target(logic [31:0] pc_plus4, logic [31:0] imm);
    return pc_plus4 + {imm[29:0], 2'b00};
  endfunction

  // Pseudo-direct jump target: upper nibble of PC+4 with the word index.
  function automatic logic [31:0] jump_target(logic [31:0] pc_plus4, logic [25:0] jidx);
    return {pc_plus4[31:28], jidx, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch evaluator: decides whether the EX instruction is
// taken and computes where fetch must go if it is.
module branch_cond_eval
  import mips_branch_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        zero_i,
  input  logic        sign_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] imm_i,
  input  logic [25:0] jidx_i,
  output logic        take_o,
  output logic [31:0] target_o
);

  branch_op_t op;

  assign op = branch_op_t'(op_i);

  // Condition and target selection; jumps use the pseudo-direct form.
  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    take_o   = branch_cond(op, zero_i, sign_i);
    target_o = branch_target(pc_plus4_i, imm_i);
    if (op == OP_J) begin
      target_o = jump_target(pc_plus4_i, jidx_i);
    end
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// EX-stage branch resolver with static predict-not-taken.
// A taken branch or jump produces a one-cycle redirect/flush pulse, then
// the stage kills incoming EX instructions for SQUASH_CYCLES cycles while
// the wrong-path instructions drain. Also keeps resolved/taken perf counters.
module branch_resolve_stage
  import mips_branch_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2,  // legal range 1..7
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             ex_valid_i,
  input  logic [2:0]       ex_branch_op_i,
  input  logic             alu_zero_i,
  input  logic             alu_sign_i,
  input  logic [31:0]      ex_pc_plus4_i,
  input  logic [31:0]      ex_imm_i,
  input  logic [25:0]      ex_jidx_i,
  output logic             redirect_o,
  output logic [31:0]      redirect_target_o,
  output logic             flush_o,
  output logic             mem_valid_o,
  output logic [CNT_W-1:0] resolved_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [SQZ_W-1:0] SQZ_INIT = SQZ_W'(SQUASH_CYCLES);

  state_t             state_q;
  logic [SQZ_W-1:0]   sqz_q;
  logic               redirect_q;
  logic               flush_q;
  logic               mem_valid_q;
  logic [31:0]        target_q;
  logic [CNT_W-1:0]   resolved_cnt_q;
  logic [CNT_W-1:0]   taken_cnt_q;

  logic               take;
  logic [31:0]        target;
  logic               is_branch_d;
  logic               fire_d;
  logic [CNT_W-1:0]   resolved_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_d;

  branch_cond_eval u_cond (
    .op_i       (ex_branch_op_i),
    .zero_i     (alu_zero_i),
    .sign_i     (alu_sign_i),
    .pc_plus4_i (ex_pc_plus4_i),
    .imm_i      (ex_imm_i),
    .jidx_i     (ex_jidx_i),
    .take_o     (take),
    .target_o   (target)
  );

  // Qualify the evaluator with ex_valid and form the wrapping counter increments.
  always_comb begin
    is_branch_d    = ex_valid_i && (branch_op_t'(ex_branch_op_i) != OP_NONE);
    fire_d         = ex_valid_i && take;
    resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
    taken_cnt_d    = taken_cnt_q + CNT_W'(1);
  end

  // Resolver FSM with registered redirect/flush/mem_valid, target and counters.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      // NOTE: the target register is reset as well; it is a single word, not
      // a memory array, and software-visible after reset.
      state_q        <= ST_IDLE;
      sqz_q          <= '0;
      redirect_q     <= 1'b0;
      flush_q        <= 1'b0;
      mem_valid_q    <= 1'b0;
      target_q       <= '0;
      resolved_cnt_q <= '0;
      taken_cnt_q    <= '0;
    end else if (!stall_i) begin
      case (state_q)
        ST_IDLE: begin
          mem_valid_q <= ex_valid_i;
          redirect_q  <= 1'b0;
          flush_q     <= 1'b0;
          if (is_branch_d) begin
            resolved_cnt_q <= resolved_cnt_d;
          end
          if (fire_d) begin
            taken_cnt_q <= taken_cnt_d;
            redirect_q  <= 1'b1;
            flush_q     <= 1'b1;
            target_q    <= target;
            sqz_q       <= SQZ_INIT;
            state_q     <= ST_SQUASH;
          end
        end
        ST_SQUASH: begin
          // Wrong-path instructions are dropped and not evaluated.
          redirect_q  <= 1'b0;
          flush_q     <= 1'b0;
          mem_valid_q <= 1'b0;
          if (sqz_q <= SQZ_W'(1)) begin
            sqz_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            sqz_q <= sqz_q - SQZ_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sqz_q   <= '0;
        end
      endcase
    end
  end

  assign redirect_o        = redirect_q;
  assign redirect_target_o = target_q;
  assign flush_o           = flush_q;
  assign mem_valid_o       = mem_valid_q;
  assign resolved_cnt_o    = resolved_cnt_q;
  assign taken_cnt_o       = taken_cnt_q;

endmodule
